car_id_thresh_ctrl: RTL and testbench
=====================================

Name: car_id_thresh_ctrl

Overview:
- Frame-synchronous controller for the car_id CbCr threshold datapath.
- Accepts threshold writes from a host into shadow registers and validates them on commit.
- Applies a valid commit only at the next v_sync rising edge, so a frame never mixes two threshold sets.
- Counts per-frame matched pixels, reported from the datapath, for host feedback and auto-tuning.

Parameters:
CB_LOW_INIT, 150, reset value of the Cb lower bound
CB_HIGH_INIT, 198, reset value of the Cb upper bound
CR_LOW_INIT, 60, reset value of the Cr lower bound
CR_HIGH_INIT, 125, reset value of the Cr upper bound
CNT_W, 22, width of the matched-pixel counter (covers 1920x1080)

Ports:
pix_clk  in  1  pixel clock; all logic on its rising edge
reset_n  in  1  asynchronous active-low reset
cfg_valid  in  1  host write strobe
cfg_ready  out  1  high when a write/commit can be accepted
cfg_addr  in  2  shadow select: 0 CB_LOW, 1 CB_HIGH, 2 CR_LOW, 3 CR_HIGH
cfg_data  in  8  write data
cfg_commit  in  1  request to apply shadow at next frame start
cfg_done  out  1  one-cycle pulse when new thresholds become active
cfg_err  out  1  one-cycle pulse when a commit is rejected
i_v_sync  in  1  frame sync, active high
i_de  in  1  data enable, aligned with i_match
i_match  in  1  datapath skin/plate match flag for the current pixel
o_cb_low  out  8  active Cb lower bound
o_cb_high  out  8  active Cb upper bound
o_cr_low  out  8  active Cr lower bound
o_cr_high  out  8  active Cr upper bound
o_match_count  out  CNT_W  matched-pixel count of the last completed frame
o_stat_valid  out  1  one-cycle pulse when o_match_count updates

Behaviour:
Reset (asynchronous, reset_n low):
- Shadow and active registers load the *_INIT values.
- o_match_count=0; internal counter=0.
- cfg_done=0, cfg_err=0, o_stat_valid=0.
- State=IDLE; cfg_ready=1.
- Registered v_sync (vs_d) resets to 1, so a v_sync held high at reset release gives no spurious edge.
- Reset asserted mid-operation aborts any pending commit and discards the counter.

Frame edge:
- vs_edge = i_v_sync & ~vs_d (combinational); vs_d <= i_v_sync every cycle.

FSM states:
- IDLE: cfg_ready=1.
  - cfg_valid=1: shadow[cfg_addr] <= cfg_data. cfg_commit is ignored in the same cycle.
  - cfg_valid=0 and cfg_commit=1, both shadow pairs valid (cb_low<cb_high and cr_low<cr_high, unsigned): go to ARMED.
  - Commit with an invalid pair: cfg_err pulses next cycle, stay IDLE, shadow retained.
- ARMED: cfg_ready=0; writes and commits are ignored, not queued. On vs_edge, go to APPLY.
  - A vs_edge in the same cycle as the commit does not count; the commit waits for the following edge.
- APPLY (exactly 1 cycle): cfg_ready=0; active <= shadow (visible next cycle); cfg_done=1 in this cycle; next state IDLE.

Latency:
- Commit accepted in cycle N gives ARMED from N+1.
- vs_edge in cycle E gives APPLY at E+1 and new o_* values from E+2.
- The datapath is in vertical blanking during these cycles.

Statistics:
- Counter increments when i_de & i_match, saturating at 2^CNT_W-1 (no wrap).
- On vs_edge: o_match_count <= counter; o_stat_valid pulses at E+1; counter loads 1 if i_de & i_match in cycle E, else 0.
- A pixel coincident with the edge belongs to the new frame.
- The first edge after reset reports 0.
- Statistics run independently of the FSM state.

Outputs:
- All outputs are registered except cfg_ready, which is decoded from state.

Test Plan:
- Reset then idle -> o_cb_low=150, o_cb_high=198, o_cr_low=60, o_cr_high=125, cfg_ready=1, all pulses 0.
- Write addr0=140, addr1=200, commit mid-frame -> cfg_ready=0, outputs unchanged until the next v_sync rise at E; cfg_done at E+1; o_cb_low=140, o_cb_high=200 at E+2; cfg_ready=1 at E+2.
- Write addr2=130 (>= CR_HIGH 125), commit -> cfg_err pulse, state IDLE, active unchanged; then write addr3=140, commit -> accepted.
- While ARMED, cfg_valid addr0=10 -> ignored; after apply, o_cb_low holds the pre-armed shadow value.
- Frame with 1000 de cycles, 37 with match, plus one match on the edge cycle -> o_match_count=37 with o_stat_valid pulse; next frame starts at 1.
- Force 2^22+5 matches in a frame -> o_match_count=4194303; reset_n low while ARMED -> active back to INIT values, no cfg_done.

Source files
------------

// File: rtl/car_id_thresh_ctrl_if.sv
// Host configuration port for car_id_thresh_ctrl.
// Carries the shadow-write and commit handshake together with its result pulses.
interface car_id_thresh_ctrl_if;
   logic       cfg_valid;
   logic       cfg_ready;
   logic [1:0] cfg_addr;
   logic [7:0] cfg_data;
   logic       cfg_commit;
   logic       cfg_done;
   logic       cfg_err;

   modport master (
      output cfg_valid, cfg_addr, cfg_data, cfg_commit,
      input  cfg_ready, cfg_done, cfg_err
   );

   modport slave (
      input  cfg_valid, cfg_addr, cfg_data, cfg_commit,
      output cfg_ready, cfg_done, cfg_err
   );
endinterface

// File: rtl/car_id_thresh_ctrl.sv
// Frame-synchronous CbCr threshold controller: shadowed host writes, commit applied
// at the next v_sync rise, and a per-frame matched-pixel counter.
module car_id_thresh_ctrl #(
   parameter logic [7:0] CB_LOW_INIT  = 8'd150,
   parameter logic [7:0] CB_HIGH_INIT = 8'd198,
   parameter logic [7:0] CR_LOW_INIT  = 8'd60,
   parameter logic [7:0] CR_HIGH_INIT = 8'd125,
   parameter int unsigned CNT_W       = 22
) (
   input  logic                 pix_clk,
   input  logic                 reset_n,
   car_id_thresh_ctrl_if.slave  cfg,
   input  logic                 i_v_sync,
   input  logic                 i_de,
   input  logic                 i_match,
   output logic [7:0]           o_cb_low,
   output logic [7:0]           o_cb_high,
   output logic [7:0]           o_cr_low,
   output logic [7:0]           o_cr_high,
   output logic [CNT_W-1:0]     o_match_count,
   output logic                 o_stat_valid
);

   typedef enum logic [1:0] {IDLE, ARMED, APPLY} state_t;

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   state_t           state_q, state_d;
   logic             vs_q;
   logic             vs_edge;
   logic [7:0]       sh_cb_low_q, sh_cb_high_q, sh_cr_low_q, sh_cr_high_q;
   logic [7:0]       cb_low_q, cb_high_q, cr_low_q, cr_high_q;
   logic             done_q, err_q;
   logic [CNT_W-1:0] cnt_q, count_q;
   logic             stat_valid_q;
   logic             pair_ok;
   logic             wr_en, commit_ok, commit_bad, apply_en;
   logic             hit;

   assign vs_edge = i_v_sync & ~vs_q;
   assign hit     = i_de & i_match;
   assign pair_ok = (sh_cb_low_q < sh_cb_high_q) && (sh_cr_low_q < sh_cr_high_q);

   always_ff @(posedge pix_clk or negedge reset_n) begin
      if (!reset_n) state_q <= IDLE;
      else          state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (!cfg.cfg_valid && cfg.cfg_commit && pair_ok) state_d = ARMED;
         ARMED:   if (vs_edge) state_d = APPLY;
         APPLY:   state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      cfg.cfg_ready = (state_q == IDLE);
      wr_en         = (state_q == IDLE) && cfg.cfg_valid;
      commit_ok     = (state_q == IDLE) && !cfg.cfg_valid && cfg.cfg_commit && pair_ok;
      commit_bad    = (state_q == IDLE) && !cfg.cfg_valid && cfg.cfg_commit && !pair_ok;
      apply_en      = (state_q == APPLY);
   end

   // vs_q resets high so a v_sync already high at reset release is not an edge
   always_ff @(posedge pix_clk or negedge reset_n) begin
      if (!reset_n) vs_q <= 1'b1;
      else          vs_q <= i_v_sync;
   end

   always_ff @(posedge pix_clk or negedge reset_n) begin
      if (!reset_n) begin
         sh_cb_low_q  <= CB_LOW_INIT;
         sh_cb_high_q <= CB_HIGH_INIT;
         sh_cr_low_q  <= CR_LOW_INIT;
         sh_cr_high_q <= CR_HIGH_INIT;
      end else if (wr_en) begin
         unique case (cfg.cfg_addr)
            2'd0: sh_cb_low_q  <= cfg.cfg_data;
            2'd1: sh_cb_high_q <= cfg.cfg_data;
            2'd2: sh_cr_low_q  <= cfg.cfg_data;
            2'd3: sh_cr_high_q <= cfg.cfg_data;
            default: ;
         endcase
      end
   end

   always_ff @(posedge pix_clk or negedge reset_n) begin
      if (!reset_n) begin
         cb_low_q  <= CB_LOW_INIT;
         cb_high_q <= CB_HIGH_INIT;
         cr_low_q  <= CR_LOW_INIT;
         cr_high_q <= CR_HIGH_INIT;
      end else if (apply_en) begin
         cb_low_q  <= sh_cb_low_q;
         cb_high_q <= sh_cb_high_q;
         cr_low_q  <= sh_cr_low_q;
         cr_high_q <= sh_cr_high_q;
      end
   end

   // done is registered on the arming edge so it coincides with the APPLY cycle
   always_ff @(posedge pix_clk or negedge reset_n) begin
      if (!reset_n) begin
         done_q <= 1'b0;
         err_q  <= 1'b0;
      end else begin
         done_q <= (state_q == ARMED) && vs_edge;
         err_q  <= commit_bad;
      end
   end

   // A hit on the edge cycle is the first pixel of the new frame
   always_ff @(posedge pix_clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt_q        <= '0;
         count_q      <= '0;
         stat_valid_q <= 1'b0;
      end else begin
         stat_valid_q <= vs_edge;
         if (vs_edge) begin
            count_q <= cnt_q;
            cnt_q   <= hit ? {{(CNT_W-1){1'b0}}, 1'b1} : '0;
         end else if (hit && (cnt_q != CNT_MAX)) begin
            cnt_q <= cnt_q + 1'b1;
         end
      end
   end

   assign cfg.cfg_done  = done_q;
   assign cfg.cfg_err   = err_q;
   assign o_cb_low      = cb_low_q;
   assign o_cb_high     = cb_high_q;
   assign o_cr_low      = cr_low_q;
   assign o_cr_high     = cr_high_q;
   assign o_match_count = count_q;
   assign o_stat_valid  = stat_valid_q;

endmodule

// File: tb/tb_car_id_thresh_ctrl.sv
// Directed self-checking bench for car_id_thresh_ctrl.
// Counter width is reduced so saturation is reachable in a short run.
module tb_car_id_thresh_ctrl;
   localparam int unsigned TB_CNT_W = 12;

   logic                pix_clk = 1'b0;
   logic                reset_n;
   logic                i_v_sync, i_de, i_match;
   logic [7:0]          o_cb_low, o_cb_high, o_cr_low, o_cr_high;
   logic [TB_CNT_W-1:0] o_match_count;
   logic                o_stat_valid;
   int                  n_cmp = 0;
   int                  n_err = 0;

   car_id_thresh_ctrl_if cfg_if ();

   car_id_thresh_ctrl #(.CNT_W(TB_CNT_W)) dut (
      .pix_clk       (pix_clk),
      .reset_n       (reset_n),
      .cfg           (cfg_if),
      .i_v_sync      (i_v_sync),
      .i_de          (i_de),
      .i_match       (i_match),
      .o_cb_low      (o_cb_low),
      .o_cb_high     (o_cb_high),
      .o_cr_low      (o_cr_low),
      .o_cr_high     (o_cr_high),
      .o_match_count (o_match_count),
      .o_stat_valid  (o_stat_valid)
   );

   always #5 pix_clk = ~pix_clk;

   task automatic tick();
      @(posedge pix_clk);
      #1;
   endtask

   task automatic wr(input logic [1:0] a, input logic [7:0] d);
      cfg_if.cfg_valid = 1'b1; cfg_if.cfg_addr = a; cfg_if.cfg_data = d;
      tick();
      cfg_if.cfg_valid = 1'b0;
   endtask

   task automatic commit();
      cfg_if.cfg_commit = 1'b1;
      tick();
      cfg_if.cfg_commit = 1'b0;
   endtask

   task automatic test_reset();
      n_cmp++; if (o_cb_low !== 8'd150) begin n_err++; $display("FAIL rst_cb_low got %0d exp 150", o_cb_low); end
      n_cmp++; if (o_cb_high !== 8'd198) begin n_err++; $display("FAIL rst_cb_high got %0d exp 198", o_cb_high); end
      n_cmp++; if (o_cr_low !== 8'd60) begin n_err++; $display("FAIL rst_cr_low got %0d exp 60", o_cr_low); end
      n_cmp++; if (o_cr_high !== 8'd125) begin n_err++; $display("FAIL rst_cr_high got %0d exp 125", o_cr_high); end
      n_cmp++; if (cfg_if.cfg_ready !== 1'b1) begin n_err++; $display("FAIL rst_ready got %b exp 1", cfg_if.cfg_ready); end
      n_cmp++; if ({cfg_if.cfg_done, cfg_if.cfg_err, o_stat_valid} !== 3'b000) begin n_err++; $display("FAIL rst_pulses got %b exp 000", {cfg_if.cfg_done, cfg_if.cfg_err, o_stat_valid}); end
      n_cmp++; if (o_match_count !== '0) begin n_err++; $display("FAIL rst_count got %0d exp 0", o_match_count); end
   endtask

   task automatic test_apply();
      wr(2'd0, 8'd140);
      wr(2'd1, 8'd200);
      commit();
      n_cmp++; if (cfg_if.cfg_ready !== 1'b0) begin n_err++; $display("FAIL armed_ready got %b exp 0", cfg_if.cfg_ready); end
      repeat (5) tick();
      n_cmp++; if (o_cb_low !== 8'd150) begin n_err++; $display("FAIL armed_hold got %0d exp 150", o_cb_low); end
      i_v_sync = 1'b1;
      tick();
      n_cmp++; if (cfg_if.cfg_done !== 1'b1) begin n_err++; $display("FAIL apply_done got %b exp 1", cfg_if.cfg_done); end
      n_cmp++; if (o_cb_low !== 8'd150) begin n_err++; $display("FAIL apply_e1_hold got %0d exp 150", o_cb_low); end
      n_cmp++; if (cfg_if.cfg_ready !== 1'b0) begin n_err++; $display("FAIL apply_ready got %b exp 0", cfg_if.cfg_ready); end
      n_cmp++; if (o_stat_valid !== 1'b1 || o_match_count !== '0) begin n_err++; $display("FAIL first_stat got v=%b c=%0d exp v=1 c=0", o_stat_valid, o_match_count); end
      i_v_sync = 1'b0;
      tick();
      n_cmp++; if ({o_cb_low, o_cb_high} !== {8'd140, 8'd200}) begin n_err++; $display("FAIL apply_cb got %0d/%0d exp 140/200", o_cb_low, o_cb_high); end
      n_cmp++; if (cfg_if.cfg_ready !== 1'b1 || cfg_if.cfg_done !== 1'b0) begin n_err++; $display("FAIL apply_e2 got rdy=%b done=%b exp 1/0", cfg_if.cfg_ready, cfg_if.cfg_done); end
   endtask

   task automatic test_invalid_commit();
      wr(2'd2, 8'd130);
      commit();
      n_cmp++; if (cfg_if.cfg_err !== 1'b1) begin n_err++; $display("FAIL bad_err got %b exp 1", cfg_if.cfg_err); end
      n_cmp++; if (cfg_if.cfg_ready !== 1'b1) begin n_err++; $display("FAIL bad_ready got %b exp 1", cfg_if.cfg_ready); end
      tick();
      n_cmp++; if (cfg_if.cfg_err !== 1'b0) begin n_err++; $display("FAIL bad_err_pulse got %b exp 0", cfg_if.cfg_err); end
      i_v_sync = 1'b1; tick(); i_v_sync = 1'b0; tick();
      n_cmp++; if (o_cr_low !== 8'd60) begin n_err++; $display("FAIL bad_no_apply got %0d exp 60", o_cr_low); end
      wr(2'd3, 8'd140);
      commit();
      n_cmp++; if (cfg_if.cfg_ready !== 1'b0 || cfg_if.cfg_err !== 1'b0) begin n_err++; $display("FAIL fix_accept got rdy=%b err=%b exp 0/0", cfg_if.cfg_ready, cfg_if.cfg_err); end
      i_v_sync = 1'b1; tick(); i_v_sync = 1'b0; tick();
      n_cmp++; if ({o_cr_low, o_cr_high} !== {8'd130, 8'd140}) begin n_err++; $display("FAIL fix_cr got %0d/%0d exp 130/140", o_cr_low, o_cr_high); end
   endtask

   task automatic test_armed_ignore();
      wr(2'd0, 8'd120);
      // commit coincident with an edge must wait for the following edge
      i_v_sync = 1'b1; commit(); i_v_sync = 1'b0;
      n_cmp++; if (cfg_if.cfg_done !== 1'b0) begin n_err++; $display("FAIL same_edge_done got %b exp 0", cfg_if.cfg_done); end
      wr(2'd0, 8'd10);
      commit();
      tick();
      n_cmp++; if (cfg_if.cfg_ready !== 1'b0 || o_cb_low !== 8'd140) begin n_err++; $display("FAIL armed_state got rdy=%b cb=%0d exp 0/140", cfg_if.cfg_ready, o_cb_low); end
      i_v_sync = 1'b1; tick();
      n_cmp++; if (cfg_if.cfg_done !== 1'b1) begin n_err++; $display("FAIL ign_done got %b exp 1", cfg_if.cfg_done); end
      i_v_sync = 1'b0; tick();
      n_cmp++; if (o_cb_low !== 8'd120) begin n_err++; $display("FAIL ign_cb_low got %0d exp 120", o_cb_low); end
      tick();
      n_cmp++; if (cfg_if.cfg_done !== 1'b0 || cfg_if.cfg_ready !== 1'b1) begin n_err++; $display("FAIL ign_after got done=%b rdy=%b exp 0/1", cfg_if.cfg_done, cfg_if.cfg_ready); end
   endtask

   task automatic test_stats();
      for (int i = 0; i < 1000; i++) begin
         i_de = 1'b1; i_match = (i % 27 == 5) && (i < 37 * 27);
         tick();
      end
      i_de = 1'b0; i_match = 1'b0;
      repeat (3) tick();
      i_v_sync = 1'b1; i_de = 1'b1; i_match = 1'b1;
      tick();
      n_cmp++; if (o_stat_valid !== 1'b1 || o_match_count !== 12'd37) begin n_err++; $display("FAIL frame_count got v=%b c=%0d exp v=1 c=37", o_stat_valid, o_match_count); end
      i_v_sync = 1'b0; i_de = 1'b0; i_match = 1'b0;
      tick();
      n_cmp++; if (o_stat_valid !== 1'b0) begin n_err++; $display("FAIL stat_pulse got %b exp 0", o_stat_valid); end
      repeat (3) tick();
      i_v_sync = 1'b1; tick(); i_v_sync = 1'b0;
      n_cmp++; if (o_match_count !== 12'd1) begin n_err++; $display("FAIL edge_pixel got %0d exp 1", o_match_count); end
   endtask

   task automatic test_saturation();
      tick();
      i_de = 1'b1; i_match = 1'b1;
      repeat (4096 + 5) tick();
      i_de = 1'b0; i_match = 1'b0;
      i_v_sync = 1'b1; tick(); i_v_sync = 1'b0;
      n_cmp++; if (o_match_count !== 12'd4095) begin n_err++; $display("FAIL sat_count got %0d exp 4095", o_match_count); end
   endtask

   task automatic test_reset_armed();
      tick();
      wr(2'd1, 8'd250);
      commit();
      n_cmp++; if (cfg_if.cfg_ready !== 1'b0) begin n_err++; $display("FAIL pre_rst_armed got %b exp 0", cfg_if.cfg_ready); end
      #2 reset_n = 1'b0;
      #1;
      n_cmp++; if ({o_cb_low, o_cb_high, o_cr_low, o_cr_high} !== {8'd150, 8'd198, 8'd60, 8'd125}) begin n_err++; $display("FAIL rst_armed_act got %0d/%0d/%0d/%0d exp 150/198/60/125", o_cb_low, o_cb_high, o_cr_low, o_cr_high); end
      n_cmp++; if (cfg_if.cfg_ready !== 1'b1 || o_match_count !== '0) begin n_err++; $display("FAIL rst_armed_st got rdy=%b c=%0d exp 1/0", cfg_if.cfg_ready, o_match_count); end
      tick(); reset_n = 1'b1; tick();
      i_v_sync = 1'b1; tick();
      n_cmp++; if (cfg_if.cfg_done !== 1'b0) begin n_err++; $display("FAIL rst_no_done got %b exp 0", cfg_if.cfg_done); end
      i_v_sync = 1'b0; tick();
      n_cmp++; if (o_cb_high !== 8'd198) begin n_err++; $display("FAIL rst_no_apply got %0d exp 198", o_cb_high); end
   endtask

   initial begin
      reset_n = 1'b0;
      cfg_if.cfg_valid = 1'b0; cfg_if.cfg_addr = '0; cfg_if.cfg_data = '0; cfg_if.cfg_commit = 1'b0;
      i_v_sync = 1'b0; i_de = 1'b0; i_match = 1'b0;
      repeat (3) tick();
      reset_n = 1'b1;
      repeat (2) tick();
      test_reset();
      test_apply();
      test_invalid_commit();
      test_armed_ignore();
      test_stats();
      test_saturation();
      test_reset_armed();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
